// File: rtl/neuron_pkg.sv
// Shared types and sizing helpers for the sequential MAC neuron.
package neuron_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        BIAS  = 2'd1,
        ADD   = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Wide enough for n full-scale products plus the shifted bias without wrapping.
    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned n_inputs);
        return 2 * width + $clog2(n_inputs + 1);
    endfunction

    function automatic longint sat_max(input int unsigned width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/neuron_sat.sv
// Rescales the accumulator to the output format and saturates it.
// Defining NEURON_MAC_RELU_EN clamps negative results to zero.
module neuron_sat
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_W     = 18,
    parameter int unsigned FRAC_BITS = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(WIDTH));

    logic signed [ACC_W-1:0] shifted;
    logic signed [WIDTH-1:0] sat;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_HI) begin
            sat = SAT_HI[WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            sat = SAT_LO[WIDTH-1:0];
        end else begin
            sat = shifted[WIDTH-1:0];
        end
`ifdef NEURON_MAC_RELU_EN
        result = sat[WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential fixed-point neuron: one MAC per accepted sample against an external
// synchronous weight ROM, then bias add and saturation (ReLU via NEURON_MAC_RELU_EN).
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned FRAC_BITS = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [DEPTH-1:0]        rom_addr_o,
    input  logic signed [WIDTH-1:0] rom_data_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int unsigned      ACC_W     = acc_width(WIDTH, N_INPUTS);
    localparam logic [DEPTH-1:0] LAST_IDX  = DEPTH'(N_INPUTS - 1);
    localparam logic [DEPTH-1:0] BIAS_ADDR = DEPTH'(N_INPUTS);

    state_e                  state;
    logic [DEPTH-1:0]        idx;
    logic [DEPTH-1:0]        rom_addr_q;
    logic signed [WIDTH-1:0] sample;
    logic                    mac_pend;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] data_q;
    logic                    valid_q;
    logic                    ready_q;

    logic signed [2*WIDTH-1:0] product;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   acc_mac;
    logic signed [ACC_W-1:0]   biased;
    logic signed [WIDTH-1:0]   sat_result;
    logic                      accept;

    assign product  = sample * rom_data_i;
    assign prod_ext = {{(ACC_W - 2 * WIDTH){product[2*WIDTH-1]}}, product};
    assign bias_ext = {{(ACC_W - WIDTH){rom_data_i[WIDTH-1]}}, rom_data_i} <<< FRAC_BITS;
    // The ROM word for a sample arrives one cycle after the accept, so the MAC trails by one.
    assign acc_mac  = mac_pend ? acc + prod_ext : acc;
    assign biased   = acc + bias_ext;
    assign accept   = (state == ACCUM) && ready_q && valid_i;

    neuron_sat #(
        .WIDTH     (WIDTH),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .acc    (biased),
        .result (sat_result)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= ACCUM;
            idx        <= '0;
            rom_addr_q <= '0;
            sample     <= '0;
            mac_pend   <= 1'b0;
            acc        <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            acc      <= acc_mac;
            mac_pend <= 1'b0;
            case (state)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        sample   <= data_i;
                        mac_pend <= 1'b1;
                        idx      <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state      <= BIAS;
                            ready_q    <= 1'b0;
                            rom_addr_q <= BIAS_ADDR;
                        end else begin
                            rom_addr_q <= idx + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    state <= ADD;
                end
                ADD: begin
                    data_q  <= sat_result;
                    valid_q <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (ready_i) begin
                        valid_q    <= 1'b0;
                        acc        <= '0;
                        idx        <= '0;
                        rom_addr_q <= '0;
                        ready_q    <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign rom_addr_o = rom_addr_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed self-checking bench for neuron_mac_seq with a synchronous weight ROM model.
module tb_neuron_mac_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [2:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;

    logic [7:0] rom_mem [0:7];
    int checks = 0;
    int errors = 0;

    // Latency as seen here: push returns on the negedge after the accepting edge;
    // valid_o must appear two negedges later (third cycle after the accept cycle).
    localparam int EXP_LAT = 2;

    neuron_mac_seq #(
        .DEPTH     (3),
        .WIDTH     (8),
        .N_INPUTS  (3),
        .FRAC_BITS (4)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .data_i     (data_in),
        .valid_i    (valid_in),
        .ready_o    (ready_out),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .data_o     (data_out),
        .valid_o    (valid_out),
        .ready_i    (ready_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic load_rom(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] b);
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_mem[3] = b;
    endtask

    task automatic push(input logic [7:0] d);
        data_in  = d;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (valid_out !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_out();
        ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = 8'h00;
        for (int i = 0; i < 8; i++) rom_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", valid_out);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h expected 00", data_out);
        end
        checks++;
        if (rom_addr !== 3'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr);
        end
        checks++;
        if (ready_out !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", ready_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL ready_after_release: got %b expected 1", ready_out);
        end
    endtask

    task automatic test_basic();
        int cyc;
        load_rom(8'h10, 8'h20, 8'hF0, 8'h08);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rom_addr !== 3'(i)) begin
                errors++; $display("FAIL basic_addr%0d: got %0d expected %0d", i, rom_addr, i);
            end
            push(8'h10);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != EXP_LAT) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, EXP_LAT);
        end
        checks++;
        if (data_out !== 8'h28) begin
            errors++; $display("FAIL basic_data: got %h expected 28", data_out);
        end
        checks++;
        if (ready_out !== 1'b0) begin
            errors++; $display("FAIL basic_ready_out_state: got %b expected 0", ready_out);
        end
        release_out();
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || rom_addr !== 3'd0) begin
            errors++;
            $display("FAIL basic_handshake: got valid=%b ready=%b addr=%0d expected 0 1 0",
                     valid_out, ready_out, rom_addr);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [7:0] exp_neg;
        load_rom(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        repeat (3) push(8'h7F);
        wait_valid(cyc);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h7F) begin
            errors++; $display("FAIL sat_pos: got %h valid=%b expected 7f", data_out, valid_out);
        end
        release_out();
`ifdef NEURON_MAC_RELU_EN
        exp_neg = 8'h00;
`else
        exp_neg = 8'h80;
`endif
        load_rom(8'h7F, 8'h7F, 8'h7F, 8'h81);
        repeat (3) push(8'h81);
        wait_valid(cyc);
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp_neg) begin
            errors++;
            $display("FAIL sat_neg: got %h valid=%b expected %h", data_out, valid_out, exp_neg);
        end
        release_out();
    endtask

    task automatic test_gaps();
        int cyc;
        load_rom(8'h10, 8'h20, 8'hF0, 8'h08);
        for (int i = 0; i < 3; i++) begin
            push(8'h10);
            if (i < 2) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    checks++;
                    if (rom_addr !== 3'(i + 1)) begin
                        errors++;
                        $display("FAIL gap_addr_hold: got %0d expected %0d", rom_addr, i + 1);
                    end
                end
            end
        end
        wait_valid(cyc);
        checks++;
        if (cyc != EXP_LAT) begin
            errors++; $display("FAIL gap_latency: got %0d expected %0d", cyc, EXP_LAT);
        end
        checks++;
        if (data_out !== 8'h28) begin
            errors++; $display("FAIL gap_data: got %h expected 28", data_out);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int cyc;
        load_rom(8'h10, 8'h20, 8'hF0, 8'h08);
        repeat (3) push(8'h10);
        wait_valid(cyc);
        data_in  = 8'h55;
        valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b1 || data_out !== 8'h28 || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b data=%h ready=%b expected 1 28 0",
                         valid_out, data_out, ready_out);
            end
        end
        valid_in = 1'b0;
        release_out();
        checks++;
        if (rom_addr !== 3'd0) begin
            errors++; $display("FAIL stall_index_clear: got %0d expected 0", rom_addr);
        end
        repeat (3) push(8'h10);
        wait_valid(cyc);
        checks++;
        if (data_out !== 8'h28) begin
            errors++; $display("FAIL stall_next_result: got %h expected 28", data_out);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int cyc;
        load_rom(8'h10, 8'h20, 8'hF0, 8'h08);
        push(8'h10);
        push(8'h10);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'h00 || rom_addr !== 3'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b data=%h addr=%0d expected 0 00 0",
                     valid_out, data_out, rom_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL midreset_ready: got %b expected 1", ready_out);
        end
        repeat (3) push(8'h10);
        wait_valid(cyc);
        checks++;
        if (cyc != EXP_LAT) begin
            errors++; $display("FAIL midreset_latency: got %0d expected %0d", cyc, EXP_LAT);
        end
        checks++;
        if (data_out !== 8'h28) begin
            errors++; $display("FAIL midreset_data: got %h expected 28", data_out);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
